// File: rtl/wishbone_arbiter_2m1s.sv
// Two-master, one-slave Wishbone arbiter. Grants are round-robin and held until ack, flush or watchdog abort.
// Each transfer returns to IDLE, so masters alternate when both are waiting.
module wishbone_arbiter_2m1s #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  output logic                  timeout_flag_o
);

  typedef enum logic [1:0] {IDLE, GNT_M0, GNT_M1} state_t;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic            last_grant, last_grant_nxt;   // 1 = m1 was served last
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic            req0, req1, granted, sel1, cyc_g, abort;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign granted = (state != IDLE);
  assign sel1    = (state == GNT_M1);
  assign cyc_g   = sel1 ? m1_cyc_i : m0_cyc_i;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wd_cnt_nxt     = '0;
    abort          = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last_grant ? GNT_M0 : GNT_M1;
        else if (req0)     state_nxt = GNT_M0;
        else if (req1)     state_nxt = GNT_M1;
      end
      GNT_M0, GNT_M1: begin
        // Ack beats the watchdog when both land in the same cycle.
        abort = (wd_cnt == WD_TERM) && !s_ack_i;
        if (s_ack_i || !cyc_g || abort) begin
          state_nxt      = IDLE;
          last_grant_nxt = sel1;
        end else begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      wd_cnt         <= '0;
      timeout_flag_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wd_cnt     <= wd_cnt_nxt;
      if (abort) timeout_flag_o <= 1'b1;
    end
  end

  // Slave side follows the granted master; everything is quiet in IDLE.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    if (granted) begin
      s_cyc_o  = sel1 ? m1_cyc_i  : m0_cyc_i;
      s_stb_o  = sel1 ? m1_stb_i  : m0_stb_i;
      s_we_o   = sel1 ? m1_we_i   : m0_we_i;
      s_addr_o = sel1 ? m1_addr_i : m0_addr_i;
      s_data_o = sel1 ? m1_data_i : m0_data_i;
      s_sel_o  = sel1 ? m1_sel_i  : m0_sel_i;
    end
  end

  assign m0_data_o = (state == GNT_M0) ? s_data_i : '0;
  assign m0_ack_o  = (state == GNT_M0) && s_ack_i;
  assign m0_err_o  = (state == GNT_M0) && abort;
  assign m1_data_o = sel1 ? s_data_i : '0;
  assign m1_ack_o  = sel1 && s_ack_i;
  assign m1_err_o  = sel1 && abort;

endmodule

// File: tb/tb_wishbone_arbiter_2m1s.sv
// Directed bench for wishbone_arbiter_2m1s with a short watchdog; acks are matched against a scoreboard queue.
module tb_wishbone_arbiter_2m1s;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic        timeout_flag_o;

  int nchecks = 0;
  int nerrors = 0;

  typedef struct packed {logic m; logic [31:0] d;} exp_t;
  exp_t sbq[$];

  wishbone_arbiter_2m1s #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .timeout_flag_o(timeout_flag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle at the falling edge and retire any ack against the scoreboard.
  task automatic look();
    exp_t e;
    @(negedge clk);
    if (m0_ack_o || m1_ack_o) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", {62'd0, m1_ack_o, m0_ack_o}, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("ack_master", {62'd0, m1_ack_o, m0_ack_o}, e.m ? 64'd2 : 64'd1);
        chk("ack_data", e.m ? m1_data_o : m0_data_o, e.d);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0;
    m0_addr_i = 32'h10; m0_data_i = '0; m0_sel_i = 4'hF;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0;
    m1_addr_i = 32'h20; m1_data_i = '0; m1_sel_i = 4'hF;
    s_data_i = '0; s_ack_i = 1'b0;

    // Reset with both masters already requesting
    step(); step();
    look();
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_ack0", m0_ack_o, 0);
    chk("rst_ack1", m1_ack_o, 0);
    chk("rst_flag", timeout_flag_o, 0);

    // Round robin: m0, m1, m0
    step(); rst = 1'b0;
    look();
    chk("rr_latency", s_cyc_o, 0);
    for (int r = 0; r < 3; r++) begin
      step(); look();
      chk("rr_cyc", s_cyc_o, 1);
      chk("rr_addr", s_addr_o, (r % 2) ? 32'h20 : 32'h10);
      step();
      s_ack_i = 1'b1; s_data_i = 32'hA0 + r;
      sbq.push_back({(r % 2) == 1, 32'hA0 + r});
      look();
      step();
      s_ack_i = 1'b0;
      if (r == 2) begin
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      end
      look();
      chk("rr_idle", s_cyc_o, 0);
    end

    // Slave ack while idle must not reach a master
    step(); s_ack_i = 1'b1; s_data_i = 32'hBAD0_0000;
    look();
    chk("idle_ack0", m0_ack_o, 0);
    chk("idle_ack1", m1_ack_o, 0);
    step(); s_ack_i = 1'b0;

    // Single m0 read, slave acks in the third granted cycle
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h0000_0100;
    look();
    chk("rd_latency", s_cyc_o, 0);
    step(); look();
    chk("rd_cyc", s_cyc_o, 1);
    chk("rd_addr", s_addr_o, 32'h100);
    chk("rd_we", s_we_o, 0);
    step(); look();
    chk("rd_noack", m0_ack_o, 0);
    step();
    s_ack_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
    sbq.push_back({1'b0, 32'hDEAD_BEEF});
    look();
    chk("rd_ack", m0_ack_o, 1);
    chk("rd_m1ack", m1_ack_o, 0);
    step();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    look();
    chk("rd_idle", s_cyc_o, 0);

    // m1 write pass-through
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_data_i = 32'h1234_5678; m1_sel_i = 4'b0011;
    look();
    step(); s_data_i = 32'h55AA_55AA;
    look();
    chk("wr_we", s_we_o, 1);
    chk("wr_data", s_data_o, 32'h1234_5678);
    chk("wr_sel", s_sel_o, 4'b0011);
    chk("wr_m0data", m0_data_o, 0);
    chk("wr_m0ack", m0_ack_o, 0);
    step();
    s_ack_i = 1'b1;
    sbq.push_back({1'b1, 32'h55AA_55AA});
    look();
    chk("wr_m0ack_t", m0_ack_o, 0);
    chk("wr_m0err", m0_err_o, 0);
    step();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    look();

    // m0 flushes in its third granted cycle while m1 waits
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    look();
    step(); look();
    chk("fl_grant", s_addr_o, 32'h100);
    step(); look();
    step(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    look();
    chk("fl_cyc", s_cyc_o, 0);
    chk("fl_ack", m0_ack_o, 0);
    step(); look();
    chk("fl_idle", s_cyc_o, 0);
    step(); look();
    chk("fl_m1cyc", s_cyc_o, 1);
    chk("fl_m1addr", s_addr_o, 32'h20);
    step();
    s_ack_i = 1'b1; s_data_i = 32'h0000_F1F1;
    sbq.push_back({1'b1, 32'h0000_F1F1});
    look();
    step(); s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    look();

    // Watchdog abort on m0 after four granted cycles
    step(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    look();
    for (int k = 0; k < 4; k++) begin
      step(); look();
      chk("to_err", m0_err_o, (k == 3) ? 64'd1 : 64'd0);
      chk("to_flag_pre", timeout_flag_o, 0);
      chk("to_m1err", m1_err_o, 0);
    end
    step(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    look();
    chk("to_flag", timeout_flag_o, 1);
    chk("to_idle", s_cyc_o, 0);
    step(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0;
    look();
    step(); look();
    chk("to_m1cyc", s_cyc_o, 1);
    step();
    s_ack_i = 1'b1; s_data_i = 32'h0000_7777;
    sbq.push_back({1'b1, 32'h0000_7777});
    look();
    step(); s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    look();
    chk("to_flag_sticky", timeout_flag_o, 1);

    // Ack lands on the terminal-count cycle
    step(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    look();
    for (int k = 0; k < 3; k++) begin
      step(); look();
    end
    step();
    s_ack_i = 1'b1; s_data_i = 32'h0000_C011;
    sbq.push_back({1'b0, 32'h0000_C011});
    look();
    chk("col_ack", m0_ack_o, 1);
    chk("col_err", m0_err_o, 0);
    step(); s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    look();

    // Reset during an m1 grant drops the pending ack
    step(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    look();
    step(); look();
    chk("rs_grant", s_cyc_o, 1);
    step(); rst = 1'b1;
    look();
    step(); s_ack_i = 1'b1; s_data_i = 32'hFFFF_0000;
    look();
    chk("rs_cyc", s_cyc_o, 0);
    chk("rs_stb", s_stb_o, 0);
    chk("rs_addr", s_addr_o, 0);
    chk("rs_ack", m1_ack_o, 0);
    chk("rs_data", m1_data_o, 0);
    chk("rs_flag", timeout_flag_o, 0);
    step(); rst = 1'b0; s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    look();
    chk("rs_idle", s_cyc_o, 0);

    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
